// File: rtl/i2c_byte_ctl.sv
// Byte-level I2C master sequencer: splits a byte command into single bit commands for the bit controller.
// Optional per-bit watchdog is built when I2C_BYTE_TIMEOUT_EN is defined.
module i2c_byte_ctl #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       i_sysclk,
  input  logic       i_reset,
  input  logic       i_go,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_read,
  input  logic       i_write,
  input  logic       i_ack,
  input  logic [7:0] i_txd,
  output logic       o_ready,
  output logic       o_done,
  output logic [7:0] o_rxd,
  output logic       o_rxack,
  output logic       o_arblost,
  output logic       o_timeout,
  output logic       o_bus_owned,
  output logic [3:0] o_bit_cmd,
  output logic       o_bit_din,
  input  logic       i_bit_ack,
  input  logic       i_bit_dout,
  input  logic       i_bit_arblost
);

  localparam logic [3:0] CMD_IDLE    = 4'b0000;
  localparam logic [3:0] CMD_START   = 4'b0001;
  localparam logic [3:0] CMD_STOP    = 4'b0010;
  localparam logic [3:0] CMD_RESTART = 4'b0011;
  localparam logic [3:0] CMD_WRITE   = 4'b0100;
  localparam logic [3:0] CMD_READ    = 4'b1000;

  // state | meaning
  // IDLE  | waiting for i_go          START | START/RESTART pulsed, awaiting ack
  // WRITE | 8 data bits out           WACK  | reading slave ACK
  // READ  | 8 data bits in            RACK  | driving master ACK/NACK
  // STOP  | STOP pulsed, awaiting ack DONE  | one-cycle completion, ready again
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WRITE, S_WACK, S_READ, S_RACK, S_STOP, S_DONE
  } state_t;

  state_t      state, state_d;
  logic        bus_owned, owned_d;
  logic        arblost_q, arblost_d;
  logic [7:0]  rxd_q, rxd_d;
  logic        rxack_q, rxack_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        din_q, din_d;
  logic [2:0]  cnt, cnt_d;
  logic [7:0]  sr, sr_d;
  logic        stop_q, stop_d, read_q, read_d, write_q, write_d, ack_q, ack_d;
  logic        issue;
  logic        busy;

`ifdef I2C_BYTE_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_q, tmo_abort;
`endif

  function automatic state_t after_start(input logic w, input logic r, input logic p);
    if (w)      return S_WRITE;
    else if (r) return S_READ;
    else if (p) return S_STOP;
    else        return S_DONE;
  endfunction

  function automatic logic [3:0] cmd_of(input state_t st, input logic owned);
    unique case (st)
      S_START:         return owned ? CMD_RESTART : CMD_START;
      S_WRITE, S_RACK: return CMD_WRITE;
      S_WACK, S_READ:  return CMD_READ;
      S_STOP:          return CMD_STOP;
      default:         return CMD_IDLE;
    endcase
  endfunction

  function automatic logic din_of(input state_t st, input logic msb, input logic ack);
    unique case (st)
      S_WRITE: return msb;
      S_RACK:  return ack;
      default: return 1'b1;
    endcase
  endfunction

  assign busy = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    state_d   = state;
    owned_d   = bus_owned;
    arblost_d = arblost_q;
    rxd_d     = rxd_q;
    rxack_d   = rxack_q;
    cnt_d     = cnt;
    sr_d      = sr;
    stop_d    = stop_q;
    read_d    = read_q;
    write_d   = write_q;
    ack_d     = ack_q;
    cmd_d     = CMD_IDLE;
    din_d     = din_q;
    issue     = 1'b0;
`ifdef I2C_BYTE_TIMEOUT_EN
    tmo_abort = 1'b0;
`endif
    if (!busy) begin
      state_d = S_IDLE;
      if (i_go) begin
        stop_d    = i_stop;
        read_d    = i_read;
        write_d   = i_write;
        ack_d     = i_ack;
        sr_d      = i_txd;
        cnt_d     = 3'd0;
        arblost_d = 1'b0;
        state_d   = i_start ? S_START : after_start(i_write, i_read, i_stop);
        issue     = 1'b1;
      end
    end else if (i_bit_arblost) begin
      arblost_d = 1'b1;
      owned_d   = 1'b0;
      state_d   = S_DONE;
    end else if (i_bit_ack) begin
      issue = 1'b1;
      unique case (state)
        S_START: begin
          owned_d = 1'b1;
          state_d = after_start(write_q, read_q, stop_q);
        end
        S_WRITE: begin
          sr_d  = {sr[6:0], 1'b0};
          cnt_d = cnt + 3'd1;
          if (cnt == 3'd7) state_d = S_WACK;
        end
        S_READ: begin
          rxd_d = {rxd_q[6:0], i_bit_dout};
          cnt_d = cnt + 3'd1;
          if (cnt == 3'd7) state_d = S_RACK;
        end
        S_WACK: begin
          rxack_d = i_bit_dout;
          state_d = stop_q ? S_STOP : S_DONE;
        end
        S_RACK:  state_d = stop_q ? S_STOP : S_DONE;
        S_STOP: begin
          owned_d = 1'b0;
          state_d = S_DONE;
        end
        default: state_d = S_DONE;
      endcase
    end
`ifdef I2C_BYTE_TIMEOUT_EN
    else if (tmo_cnt == 16'd0) begin
      owned_d   = 1'b0;
      state_d   = S_DONE;
      tmo_abort = 1'b1;
    end
`endif
    // Command code is only ever a single-cycle pulse on the transition into a bit state
    if (issue) begin
      cmd_d = cmd_of(state_d, owned_d);
      din_d = din_of(state_d, sr_d[7], ack_d);
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      bus_owned <= 1'b0;
      arblost_q <= 1'b0;
      rxd_q     <= 8'h00;
      rxack_q   <= 1'b1;
      cmd_q     <= CMD_IDLE;
      din_q     <= 1'b1;
      cnt       <= 3'd0;
      sr        <= 8'h00;
      stop_q    <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state     <= state_d;
      bus_owned <= owned_d;
      arblost_q <= arblost_d;
      rxd_q     <= rxd_d;
      rxack_q   <= rxack_d;
      cmd_q     <= cmd_d;
      din_q     <= din_d;
      cnt       <= cnt_d;
      sr        <= sr_d;
      stop_q    <= stop_d;
      read_q    <= read_d;
      write_q   <= write_d;
      ack_q     <= ack_d;
    end
  end

`ifdef I2C_BYTE_TIMEOUT_EN
  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      tmo_cnt <= 16'd0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= tmo_abort;
      if (issue)
        tmo_cnt <= 16'(TIMEOUT_CYCLES);
      else if (busy && (tmo_cnt != 16'd0))
        tmo_cnt <= tmo_cnt - 16'd1;
    end
  end
  assign o_timeout = tmo_q;
`else
  logic tmo_param_unused;
  assign tmo_param_unused = ^16'(TIMEOUT_CYCLES);
  assign o_timeout = 1'b0;
`endif

  assign o_ready     = !busy;
  assign o_done      = (state == S_DONE);
  assign o_rxd       = rxd_q;
  assign o_rxack     = rxack_q;
  assign o_arblost   = arblost_q;
  assign o_bus_owned = bus_owned;
  assign o_bit_cmd   = cmd_q;
  assign o_bit_din   = din_q;

endmodule

// File: tb/tb_i2c_byte_ctl.sv
// Bench for i2c_byte_ctl: table of byte commands against a bit-controller stand-in, plus reset/timeout sequences.
module tb_i2c_byte_ctl;

  localparam logic [3:0] C_IDLE    = 4'b0000;
  localparam logic [3:0] C_START   = 4'b0001;
  localparam logic [3:0] C_STOP    = 4'b0010;
  localparam logic [3:0] C_RESTART = 4'b0011;
  localparam logic [3:0] C_WRITE   = 4'b0100;
  localparam logic [3:0] C_READ    = 4'b1000;

`ifdef I2C_BYTE_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 65535;
`endif

  logic       i_sysclk = 1'b0;
  logic       i_reset, i_go, i_start, i_stop, i_read, i_write, i_ack;
  logic [7:0] i_txd;
  logic       o_ready, o_done, o_rxack, o_arblost, o_timeout, o_bus_owned, o_bit_din;
  logic [7:0] o_rxd;
  logic [3:0] o_bit_cmd;
  logic       i_bit_ack, i_bit_dout, i_bit_arblost;

  i2c_byte_ctl #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_sysclk(i_sysclk), .i_reset(i_reset), .i_go(i_go), .i_start(i_start),
    .i_stop(i_stop), .i_read(i_read), .i_write(i_write), .i_ack(i_ack),
    .i_txd(i_txd), .o_ready(o_ready), .o_done(o_done), .o_rxd(o_rxd),
    .o_rxack(o_rxack), .o_arblost(o_arblost), .o_timeout(o_timeout),
    .o_bus_owned(o_bus_owned), .o_bit_cmd(o_bit_cmd), .o_bit_din(o_bit_din),
    .i_bit_ack(i_bit_ack), .i_bit_dout(i_bit_dout), .i_bit_arblost(i_bit_arblost)
  );

  always #5 i_sysclk = ~i_sysclk;

  typedef struct packed {
    logic        start, stop, read, write, ack;
    logic [7:0]  txd;
    logic [7:0]  rd_bits;
    logic        wack;
    logic [7:0]  arb_n;
    logic [7:0]  ncmd;
    logic [3:0]  f_cmd, l_cmd;
    logic [15:0] din_log;
    logic [7:0]  rxd;
    logic        rxack, owned, arb;
  } vec_t;

  vec_t vecs [10];
  int   n_chk = 0;
  int   n_bad = 0;
  int   cur   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL v%0d %s: got %0h, want %0h", cur, name, act, exp);
    end
  endtask

  task automatic reset_checks();
    check("rst_ready",   16'(o_ready),     16'h1);
    check("rst_done",    16'(o_done),      16'h0);
    check("rst_rxd",     16'(o_rxd),       16'h0);
    check("rst_rxack",   16'(o_rxack),     16'h1);
    check("rst_arblost", 16'(o_arblost),   16'h0);
    check("rst_timeout", 16'(o_timeout),   16'h0);
    check("rst_owned",   16'(o_bus_owned), 16'h0);
    check("rst_cmd",     16'(o_bit_cmd),   16'(C_IDLE));
    check("rst_din",     16'(o_bit_din),   16'h1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          n, wr, dly;
    logic        pend, ack_prev, got_done, hold;
    logic [3:0]  last;
    logic [15:0] dlog;
    logic [7:0]  rsh;
    cur = idx; n = 0; wr = 0; dly = 0; pend = 1'b0; ack_prev = 1'b0; got_done = 1'b0;
    hold = 1'b1; last = C_IDLE; dlog = 16'h0; rsh = v.rd_bits;
    @(negedge i_sysclk);
    i_go = 1'b1; i_start = v.start; i_stop = v.stop; i_read = v.read;
    i_write = v.write; i_ack = v.ack; i_txd = v.txd;
    @(negedge i_sysclk);
    i_go = 1'b0;
    check("arblost_cleared", 16'(o_arblost), 16'h0);
    check("first_cmd", 16'(o_bit_cmd), 16'(v.f_cmd));
    if (v.ncmd != 8'd0) check("ready_low", 16'(o_ready), 16'h0);
    for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
      if (cyc > 0) @(negedge i_sysclk);
      if (ack_prev) check("next_pulse", 16'((o_bit_cmd != C_IDLE) || o_done), 16'h1);
      ack_prev = 1'b0; i_bit_ack = 1'b0; i_bit_arblost = 1'b0; i_go = 1'b0;
      if (o_done) got_done = 1'b1;
      else begin
        if (o_bit_cmd != C_IDLE) begin
          check("one_cmd_at_a_time", 16'(pend), 16'h0);
          n++; last = o_bit_cmd; hold = o_bit_din; pend = 1'b1; dly = 2;
          if (o_bit_cmd == C_WRITE) begin
            dlog = {dlog[14:0], o_bit_din};
            wr++;
          end
          if (n == 1) i_go = 1'b1;  // strobe while busy must be ignored
        end else if (pend) check("din_hold", 16'(o_bit_din), 16'(hold));
        if (pend) begin
          if (dly == 0) begin
            i_bit_ack = 1'b1; pend = 1'b0; ack_prev = 1'b1; i_bit_dout = 1'b1;
            if (last == C_READ) begin
              if (v.write) i_bit_dout = v.wack;
              else begin
                i_bit_dout = rsh[7];
                rsh = {rsh[6:0], 1'b0};
              end
            end
            if (v.arb_n != 8'd0 && last == C_WRITE && wr == int'(v.arb_n)) i_bit_arblost = 1'b1;
          end else dly--;
        end
      end
    end
    check("done_seen",    16'(got_done),    16'h1);
    check("done_ready",   16'(o_ready),     16'h1);
    check("done_cmd",     16'(o_bit_cmd),   16'(C_IDLE));
    check("ncmd",         16'(n),           16'(v.ncmd));
    check("last_cmd",     16'(last),        16'(v.l_cmd));
    check("din_seq",      dlog,             v.din_log);
    check("rxd",          16'(o_rxd),       16'(v.rxd));
    check("rxack",        16'(o_rxack),     16'(v.rxack));
    check("bus_owned",    16'(o_bus_owned), 16'(v.owned));
    check("arblost",      16'(o_arblost),   16'(v.arb));
    check("timeout",      16'(o_timeout),   16'h0);
    @(negedge i_sysclk);
    check("done_1cycle",  16'(o_done),      16'h0);
    check("idle_cmd",     16'(o_bit_cmd),   16'(C_IDLE));
    check("arb_sticky",   16'(o_arblost),   16'(v.arb));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  initial begin
    int  rdn;
    logic hit;
    // start stop read write ack txd rd wack arb_n ncmd first last din_log rxd rxack owned arb
    vecs[0] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 8'hA5, 8'h00, 1'b0, 8'd0, 8'd10, C_START,   C_READ,  16'h00A5, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0,1'b1,1'b1,1'b0,1'b1, 8'h00, 8'hCA, 1'b0, 8'd0, 8'd10, C_READ,    C_STOP,  16'h0001, 8'hCA, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 8'h3C, 8'h00, 1'b1, 8'd0, 8'd11, C_START,   C_STOP,  16'h003C, 8'hCA, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00, 8'h00, 1'b0, 8'd0, 8'd1,  C_START,   C_START, 16'h0000, 8'hCA, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1,1'b0,1'b1,1'b1,1'b0, 8'h81, 8'h00, 1'b0, 8'd0, 8'd10, C_RESTART, C_READ,  16'h0081, 8'hCA, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 8'h00, 8'h5B, 1'b0, 8'd0, 8'd9,  C_READ,    C_WRITE, 16'h0000, 8'h5B, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 8'h00, 1'b0, 8'd0, 8'd0,  C_IDLE,    C_IDLE,  16'h0000, 8'h5B, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 8'hA5, 8'h00, 1'b0, 8'd3, 8'd4,  C_RESTART, C_WRITE, 16'h0005, 8'h5B, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 8'h00, 8'h00, 1'b0, 8'd0, 8'd1,  C_STOP,    C_STOP,  16'h0000, 8'h5B, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 8'hFF, 8'h00, 1'b1, 8'd0, 8'd10, C_WRITE,   C_STOP,  16'h00FF, 8'h5B, 1'b1, 1'b0, 1'b0};

    i_reset = 1'b1; i_go = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_read = 1'b0;
    i_write = 1'b0; i_ack = 1'b0; i_txd = 8'h00;
    i_bit_ack = 1'b0; i_bit_dout = 1'b1; i_bit_arblost = 1'b0;
    repeat (3) @(posedge i_sysclk);
    @(negedge i_sysclk);
    cur = -1;
    reset_checks();
    i_reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset while the fifth read bit is outstanding
    cur = 10;
    @(negedge i_sysclk);
    i_go = 1'b1; i_start = 1'b1; i_read = 1'b1; i_stop = 1'b1; i_write = 1'b0;
    @(negedge i_sysclk);
    i_go = 1'b0;
    rdn = 0; hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (c > 0) @(negedge i_sysclk);
      i_bit_ack = 1'b0;
      if (o_bit_cmd == C_READ) begin
        rdn++;
        if (rdn == 5) begin
          check("rxd_before_reset",   16'(o_rxd),       16'h00BF);
          check("owned_before_reset", 16'(o_bus_owned), 16'h1);
          i_reset = 1'b1;
          hit = 1'b1;
        end else begin
          i_bit_ack = 1'b1; i_bit_dout = 1'b1;
        end
      end else if (o_bit_cmd != C_IDLE) begin
        i_bit_ack = 1'b1; i_bit_dout = 1'b1;
      end
    end
    check("reset_point_reached", 16'(hit), 16'h1);
    @(negedge i_sysclk);
    reset_checks();
    i_reset = 1'b0; i_start = 1'b0; i_read = 1'b0; i_stop = 1'b0;
    repeat (4) begin
      @(negedge i_sysclk);
      check("no_stop_after_reset", 16'(o_bit_cmd), 16'(C_IDLE));
      check("no_done_after_reset", 16'(o_done),    16'h0);
    end

`ifdef I2C_BYTE_TIMEOUT_EN
    cur = 11;
    @(negedge i_sysclk);
    i_go = 1'b1; i_write = 1'b1; i_txd = 8'h00;
    @(negedge i_sysclk);
    i_go = 1'b0; i_write = 1'b0;
    check("tmo_pulse", 16'(o_bit_cmd), 16'(C_WRITE));
    for (int k = 1; k <= 17; k++) begin
      @(negedge i_sysclk);
      if (k == 16) begin
        check("tmo_early_done", 16'(o_done),    16'h0);
        check("tmo_early_flag", 16'(o_timeout), 16'h0);
      end
      if (k == 17) begin
        check("tmo_done",    16'(o_done),      16'h1);
        check("tmo_flag",    16'(o_timeout),   16'h1);
        check("tmo_arblost", 16'(o_arblost),   16'h0);
        check("tmo_owned",   16'(o_bus_owned), 16'h0);
      end
    end
    @(negedge i_sysclk);
    check("tmo_1cycle", 16'(o_timeout), 16'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_byte_ctl.md
# i2c_byte_ctl

Byte-level I2C master sequencer between the register/host interface and the I2C bit controller. It accepts one byte command (optional START/RESTART, write or read of 8 bits with ACK phase, optional STOP). It breaks the command into single bit commands using the `CMD_*` codes from `i2c-def.v`, handshakes each one against the bit controller's command acknowledge, and returns the received byte, the received ACK and the error status.

## Interface
- `TIMEOUT_CYCLES`, default 65535: watchdog limit, in `i_sysclk` cycles, per bit command. Used only with `I2C_BYTE_TIMEOUT_EN`.
- `i_sysclk`  in  1  system clock; the only clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_go`  in  1  command strobe; accepted only when `o_ready`=1.
- `i_start`, `i_stop`, `i_read`, `i_write`  in  1 each  command flags, sampled with `i_go`.
- `i_ack`  in  1  ACK value to send after a read (0=ACK, 1=NACK).
- `i_txd`  in  8  byte to write, MSB first.
- `o_ready`  out  1  idle, can accept `i_go`.
- `o_done`  out  1  one-cycle pulse at command end, including aborted commands.
- `o_rxd`  out  8  byte read, MSB first.
- `o_rxack`  out  1  ACK bit sampled after a write.
- `o_arblost`  out  1  sticky arbitration-lost flag; cleared by the next accepted `i_go`.
- `o_timeout`  out  1  one-cycle pulse on watchdog abort.
- `o_bus_owned`  out  1  set after START completes; cleared after STOP, arbitration loss or timeout.
- `o_bit_cmd`  out  4  bit command to the bit controller.
- `o_bit_din`  out  1  SDA data bit to the bit controller.
- `i_bit_ack`  in  1  bit command complete (one-cycle pulse).
- `i_bit_dout`  in  1  sampled SDA from the bit controller.
- `i_bit_arblost`  in  1  arbitration lost, from the bit controller.

## Operation
- Reset values:
  - `o_ready`=1, `o_done`=0, `o_rxd`=0, `o_rxack`=1, `o_arblost`=0, `o_timeout`=0, `o_bus_owned`=0.
  - `o_bit_cmd`=`CMD_IDLE`, `o_bit_din`=1, state=`IDLE`.
  - A reset asserted mid-command forces these values on the next edge. No STOP is issued.
- FSM states: `IDLE`, `START`, `WRITE`, `WACK`, `READ`, `RACK`, `STOP`, `DONE`.
- `IDLE` + `i_go`: latch all flags, `i_txd` and `i_ack`; clear `o_arblost`. Then go to the first applicable state in this order: `START`, `WRITE`/`READ`, `STOP`, `DONE`.
- `START`: issues `CMD_RESTART` if `o_bus_owned`=1, otherwise `CMD_START`. On ack, set `o_bus_owned`.
- `WRITE`: 8 × `CMD_WRITE`. `o_bit_din` carries the current bit, MSB first, and is held stable until that bit's ack.
- `WACK`: 1 × `CMD_READ`. `i_bit_dout` at ack goes to `o_rxack`.
- `READ`: 8 × `CMD_READ`. `i_bit_dout` at each ack shifts into `o_rxd` LSB.
- `RACK`: 1 × `CMD_WRITE` with `o_bit_din` = latched `i_ack`.
- `STOP`: `CMD_STOP`. On ack, clear `o_bus_owned`.
- If `i_read` and `i_write` are both set, the command is a write only. A command with no flags set goes directly to `DONE`.
- A 3-bit counter counts data bits; it wraps 7→0 at the transition to the ACK phase.
- `i_bit_arblost`=1 in any non-IDLE state aborts the command:
  - `o_bit_cmd`=`CMD_IDLE`, set `o_arblost`, clear `o_bus_owned`, go to `DONE`.
  - This takes priority over a simultaneous `i_bit_ack`.

## Timing
- `o_bit_cmd` is a one-cycle pulse of the command code. It is `CMD_IDLE` on every other cycle, so the bit controller never re-latches a command when it returns to idle.
- The first bit command is pulsed on the cycle after `i_go` is accepted; `o_ready` falls on that same cycle.
- The next bit command is pulsed exactly one cycle after the `i_bit_ack` cycle.
- `DONE` lasts one cycle, with `o_done`=1 and `o_ready`=1 together.
- `o_rxd` and `o_rxack` are valid from `o_done` until the next accepted `i_go`.
- `i_go` while `o_ready`=0 is ignored.

## Configuration
- `I2C_BYTE_TIMEOUT_EN` defined: a 16-bit counter reloads to `TIMEOUT_CYCLES` on each bit command pulse and decrements while waiting for `i_bit_ack`. When it reaches 0, the command aborts:
  - same abort action as arbitration loss, without setting `o_arblost`;
  - `o_timeout` pulses on the same cycle as `o_done`.
- `I2C_BYTE_TIMEOUT_EN` undefined: no counter is built, `o_timeout` is tied to 0, and the block waits indefinitely for `i_bit_ack`.

## Test plan
- Write with START: `i_go` with `i_start`=1, `i_write`=1, `i_txd`=8'hA5, bench ack with `i_bit_dout`=0 on the ACK read → pulses START, then WRITE with din 1,0,1,0,0,1,0,1, then READ; `o_rxack`=0, `o_bus_owned`=1, one `o_done`.
- Read with NACK and STOP: `i_read`=1, `i_ack`=1, `i_stop`=1, `i_bit_dout` = 1,1,0,0,1,0,1,0 → `o_rxd`=8'hCA; RACK WRITE with din=1; STOP pulse; `o_bus_owned`=0.
- Repeated start: START command while `o_bus_owned`=1 → `o_bit_cmd`=`CMD_RESTART`, not `CMD_START`.
- Arbitration: `i_bit_arblost` on the 3rd write bit, same cycle as `i_bit_ack` → next cycle `o_done`=1, `o_arblost`=1, `o_bus_owned`=0, no further commands; the next `i_go` clears `o_arblost`.
- Reset mid-read: `i_reset` during the 5th read bit → next cycle all outputs at reset values, `o_bit_cmd`=`CMD_IDLE`.
- Timeout (`I2C_BYTE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): no `i_bit_ack` after a WRITE pulse → `o_timeout` and `o_done` together 17 cycles after the pulse, `o_arblost`=0.
